// File: rtl/seq_byte_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : seq_byte_stream_fifo
//  Purpose  : First-word-fall-through byte FIFO placed after the byte capture
//             register. Valid/ready handshakes on both sides let the consumer
//             stall without losing bytes. An occupancy high-water mark is
//             kept for debug.
//  Ports    : clk        - clock, all state updates on posedge
//             rst_n      - synchronous reset, active-low
//             flush      - synchronous clear of FIFO contents
//             in_valid   - producer presents a byte on in_data
//             in_data    - byte from the capture register
//             in_ready   - FIFO can accept a byte this cycle
//             out_valid  - out_data holds the oldest stored byte
//             out_data   - head of the FIFO (zero when empty)
//             out_ready  - consumer takes the head this cycle
//             count      - current occupancy, 0..DEPTH
//             max_count  - highest occupancy seen since reset
//  Revision : 1.0  initial release
// ============================================================================
module seq_byte_stream_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    max_count
);

  // Pointer width; DEPTH is a power of two so pointers wrap on their own.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             push;
  logic             pop;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    max_nxt;

  // Ready and valid come from registered occupancy only, so neither handshake
  // side has a combinational path into the other.
  assign in_ready  = rst_n & (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // A push while full is blocked even if a pop happens in the same cycle.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // count never exceeds DEPTH, so the high-water mark saturates there too.
  // A flush drives count_nxt to zero, leaving the mark untouched.
  assign max_nxt = (count_nxt > max_count) ? count_nxt : max_count;

  // Storage is deliberately not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_count <= max_nxt;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count_nxt;
      max_count <= max_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_byte_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_byte_stream_fifo
//  Purpose  : Self-checking bench for seq_byte_stream_fifo. Directed vectors
//             hold inputs and the expected outputs after the following edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_byte_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic [CW-1:0]    max_count;

  int tests_run = 0;
  int tests_failed = 0;

  seq_byte_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .max_count (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         out_ready;
    logic         exp_in_ready;
    logic         exp_out_valid;
    logic [7:0]   exp_out_data;
    logic [CW-1:0] exp_count;
    logic [CW-1:0] exp_max;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [7:0] d, input logic ordy,
                              input logic ir, input logic ov,
                              input logic [7:0] od, input logic [CW-1:0] c,
                              input logic [CW-1:0] m);
    vec_t v;
    v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_in_ready = ir; v.exp_out_valid = ov; v.exp_out_data = od;
    v.exp_count = c; v.exp_max = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    rst_n     = v.rst_n;
    flush     = v.flush;
    in_valid  = v.in_valid;
    in_data   = v.in_data;
    out_ready = v.out_ready;
    @(posedge clk);
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".in_ready"},  {7'd0, in_ready},     {7'd0, v.exp_in_ready});
    chk({tag, ".out_valid"}, {7'd0, out_valid},    {7'd0, v.exp_out_valid});
    chk({tag, ".out_data"},  out_data,             v.exp_out_data);
    chk({tag, ".count"},     8'(count),            8'(v.exp_count));
    chk({tag, ".max_count"}, 8'(max_count),        8'(v.exp_max));
  endtask

  vec_t pre_tab  [11];
  vec_t post_tab [11];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //                  rst flu iv  data   ordy  ir ov data   cnt max
    // Reset held two cycles
    pre_tab[0]  = mk(0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0);
    pre_tab[1]  = mk(0, 0, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0);
    // Fill with consumer stalled
    pre_tab[2]  = mk(1, 0, 1, 8'h11, 0,   1, 1, 8'h11, 1, 1);
    pre_tab[3]  = mk(1, 0, 1, 8'h22, 0,   1, 1, 8'h11, 2, 2);
    pre_tab[4]  = mk(1, 0, 1, 8'h33, 0,   1, 1, 8'h11, 3, 3);
    pre_tab[5]  = mk(1, 0, 1, 8'h44, 0,   0, 1, 8'h11, 4, 4);
    // Fifth byte offered while full: refused
    pre_tab[6]  = mk(1, 0, 1, 8'h55, 0,   0, 1, 8'h11, 4, 4);
    // Drain from full; 8'h55 must never appear
    pre_tab[7]  = mk(1, 0, 0, 8'h00, 1,   1, 1, 8'h22, 3, 4);
    pre_tab[8]  = mk(1, 0, 0, 8'h00, 1,   1, 1, 8'h33, 2, 4);
    pre_tab[9]  = mk(1, 0, 0, 8'h00, 1,   1, 1, 8'h44, 1, 4);
    pre_tab[10] = mk(1, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 4);

    // Build occupancy 3, then flush with a byte offered
    post_tab[0]  = mk(1, 0, 1, 8'hA1, 0,  1, 1, 8'hA1, 1, 4);
    post_tab[1]  = mk(1, 0, 1, 8'hB2, 0,  1, 1, 8'hA1, 2, 4);
    post_tab[2]  = mk(1, 0, 1, 8'hC3, 0,  1, 1, 8'hA1, 3, 4);
    post_tab[3]  = mk(1, 1, 1, 8'hDD, 0,  1, 0, 8'h00, 0, 4);
    post_tab[4]  = mk(1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 4);
    // Refill to 2, then push+pop together, then reset mid-operation
    post_tab[5]  = mk(1, 0, 1, 8'hE1, 0,  1, 1, 8'hE1, 1, 4);
    post_tab[6]  = mk(1, 0, 1, 8'hE2, 0,  1, 1, 8'hE1, 2, 4);
    post_tab[7]  = mk(1, 0, 1, 8'hE3, 1,  1, 1, 8'hE2, 2, 4);
    post_tab[8]  = mk(0, 0, 1, 8'hE4, 1,  0, 0, 8'h00, 0, 0);
    post_tab[9]  = mk(1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0);
    post_tab[10] = mk(1, 0, 1, 8'h77, 0,  1, 1, 8'h77, 1, 1);

    @(negedge clk);
    for (int i = 0; i < 11; i++) apply(pre_tab[i], i);

    // Streaming: producer and consumer both active, occupancy stays at one
    // and the bytes come out in order while the pointers wrap several times.
    for (int i = 0; i < 20; i++) begin
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.out_data", i), out_data, 8'(i));
      chk($sformatf("stream%0d.count", i), 8'(count), 8'd1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_end.count", 8'(count), 8'd0);
    chk("stream_end.max_count", 8'(max_count), 8'd4);

    for (int i = 0; i < 11; i++) apply(post_tab[i], 100 + i);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
`default_nettype wire
